vector_vector_alu_v2: RTL

- Second-generation vector-vector ALU stage of the trace-processing pipeline.
- Combines each incoming N-lane vector with an operand vector from a private vector register file (VVRF) and optionally caches the result back.
- Driven by per-chain firmware tables loaded over the byte-serial config bus.
- Additions over the previous generation: signed fixed-point math with saturation, min and abs-diff ops, write-first RAW forwarding, atomic shadow-table config commit with done/error status, and full async reset.

---
 rtl/vector_vector_alu_v2.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vector_vector_alu_v2.sv
// Two-stage vector-vector ALU with a private vector register file, per-chain firmware tables,
// and a byte-serial shadow-table loader. valid_in/valid_out are a plain qualifier with no backpressure.
module vector_vector_alu_v2 #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int FRAC_BITS          = 16,
    parameter int SIGNED             = 1,
    parameter int SATURATE           = 1,
    parameter int MAX_CHAINS         = 4,
    parameter int VVRF_SIZE          = 8,
    parameter int PERSONAL_CONFIG_ID = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tracing,
    input  logic                                valid_in,
    input  logic [1:0]                          eof_in,
    input  logic [1:0]                          bof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0]       chainId_in,
    input  logic [7:0]                          configId,
    input  logic [7:0]                          configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
    output logic                                valid_out,
    output logic [1:0]                          eof_out,
    output logic [1:0]                          bof_out,
    output logic [$clog2(MAX_CHAINS)-1:0]       chainId_out,
    output logic                                cfg_done,
    output logic                                cfg_error
);
    localparam int W     = DATA_WIDTH;
    localparam int P     = 2 * W + 2;
    localparam int CW    = $clog2(MAX_CHAINS);
    localparam int AW    = $clog2(VVRF_SIZE);
    localparam int TOTAL = 5 * MAX_CHAINS;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef enum logic {IDLE, LOAD} cfg_state_t;

    // All arithmetic is done in a P-bit signed domain wide enough for the full product.
    function automatic logic signed [P-1:0] ext(input logic [W-1:0] x);
        if (SIGNED != 0) return {{(P-W){x[W-1]}}, x};
        return {{(P-W){1'b0}}, x};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [P-1:0] v);
        logic signed [P-1:0] max_v;
        logic signed [P-1:0] min_v;
        if (SIGNED != 0) begin
            max_v = {{(P-W+1){1'b0}}, {(W-1){1'b1}}};
            min_v = {{(P-W+1){1'b1}}, {(W-1){1'b0}}};
        end else begin
            max_v = {{(P-W){1'b0}}, {W{1'b1}}};
            min_v = '0;
        end
        if (SATURATE == 0) return v[W-1:0];
        if (v > max_v) return max_v[W-1:0];
        if (v < min_v) return min_v[W-1:0];
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] alu(input logic [7:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic signed [P-1:0] ea;
        logic signed [P-1:0] eb;
        logic signed [P-1:0] r;
        ea = ext(a);
        eb = ext(b);
        r  = '0;
        case (op)
            8'd1: return sat(ea + eb);
            8'd2: begin
                r = ea * eb;
                r = r >>> FRAC_BITS;
                return sat(r);
            end
            8'd3: return sat(ea - eb);
            8'd4: return (ea > eb) ? a : b;
            8'd5: return (ea < eb) ? a : b;
            8'd6: begin
                r = ea - eb;
                if (r < 0) r = -r;
                return sat(r);
            end
            8'd7: return b;
            default: return a;
        endcase
    endfunction

    function automatic logic cond_ok(input logic [7:0] c, input logic [1:0] eof, input logic [1:0] bof);
        case (c)
            8'd0: return 1'b1;
            8'd1: return eof[0];
            8'd2: return !eof[0];
            8'd3: return bof[0];
            8'd4: return !bof[0];
            8'd5: return eof[1];
            8'd6: return !eof[1];
            8'd7: return bof[1];
            8'd8: return !bof[1];
            default: return 1'b0;
        endcase
    endfunction

    // Firmware tables: active drives the datapath, shadow collects a load until it commits.
    logic [7:0]    act_op_q    [MAX_CHAINS];
    logic [AW-1:0] act_rd_q    [MAX_CHAINS];
    logic [7:0]    act_cond_q  [MAX_CHAINS];
    logic          act_cache_q [MAX_CHAINS];
    logic [AW-1:0] act_caddr_q [MAX_CHAINS];
    logic [7:0]    sh_op_q     [MAX_CHAINS];
    logic [AW-1:0] sh_rd_q     [MAX_CHAINS];
    logic [7:0]    sh_cond_q   [MAX_CHAINS];
    logic          sh_cache_q  [MAX_CHAINS];
    logic [AW-1:0] sh_caddr_q  [MAX_CHAINS];

    cfg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
    logic             err_q, err_d, done_q, sh_we, commit, cfg_sel;
    logic [2:0]       wr_fld;
    logic [CW-1:0]    wr_ch;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sh_we   = 1'b0;
        commit  = 1'b0;
        wr_idx  = cnt_q;
        cfg_sel = !tracing && (configId == 8'(PERSONAL_CONFIG_ID));
        case (state_q)
            IDLE: if (cfg_sel) begin
                state_d = LOAD;
                wr_idx  = '0;
                sh_we   = 1'b1;
                cnt_d   = CNT_W'(1);
                err_d   = 1'b0;
            end
            LOAD: if (cfg_sel) begin
                if (cnt_q < CNT_W'(TOTAL)) begin
                    sh_we = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = IDLE;
                if (cnt_q == CNT_W'(TOTAL) && !err_q) commit = 1'b1;
                else                                  err_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        wr_fld = 3'(wr_idx / CNT_W'(MAX_CHAINS));
        wr_ch  = CW'(wr_idx % CNT_W'(MAX_CHAINS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= commit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                act_op_q[c] <= '0; act_rd_q[c] <= '0; act_cond_q[c] <= '0;
                act_cache_q[c] <= 1'b0; act_caddr_q[c] <= '0;
                sh_op_q[c] <= '0; sh_rd_q[c] <= '0; sh_cond_q[c] <= '0;
                sh_cache_q[c] <= 1'b0; sh_caddr_q[c] <= '0;
            end
        end else begin
            if (sh_we) begin
                case (wr_fld)
                    3'd0: sh_op_q[wr_ch]    <= configData;
                    3'd1: sh_rd_q[wr_ch]    <= configData[AW-1:0];
                    3'd2: sh_cond_q[wr_ch]  <= configData;
                    3'd3: sh_cache_q[wr_ch] <= configData[0];
                    3'd4: sh_caddr_q[wr_ch] <= configData[AW-1:0];
                    default: ;
                endcase
            end
            if (commit) begin
                act_op_q    <= sh_op_q;
                act_rd_q    <= sh_rd_q;
                act_cond_q  <= sh_cond_q;
                act_cache_q <= sh_cache_q;
                act_caddr_q <= sh_caddr_q;
            end
        end
    end

    // Datapath: S1 holds the captured vector and operand, S2 is the output register.
    vec_t          vvrf_q [VVRF_SIZE];
    vec_t          s1_vec_q, s1_opnd_q, opnd_d, res_d, vec_out_q;
    logic          s1_valid_q, s1_cache_q, wr_en, c_ok, valid_out_q;
    logic [1:0]    s1_eof_q, s1_bof_q, eof_out_q, bof_out_q;
    logic [CW-1:0] s1_chain_q, chain_out_q;
    logic [7:0]    s1_op_q, s1_cond_q;
    logic [AW-1:0] s1_caddr_q, rd_addr;

    always_comb begin
        c_ok = cond_ok(s1_cond_q, s1_eof_q, s1_bof_q);
        for (int i = 0; i < N; i++)
            res_d[i] = c_ok ? alu(s1_op_q, s1_vec_q[i], s1_opnd_q[i]) : s1_vec_q[i];
        wr_en   = s1_valid_q && tracing && s1_cache_q;
        rd_addr = act_rd_q[chainId_in];
        // Write-first: a same-edge write to the read address is forwarded into S1.
        opnd_d  = (wr_en && s1_caddr_q == rd_addr) ? res_d : vvrf_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s1_vec_q <= '0; s1_opnd_q <= '0;
            s1_eof_q <= '0; s1_bof_q <= '0; s1_chain_q <= '0;
            s1_op_q <= '0; s1_cond_q <= '0; s1_cache_q <= 1'b0; s1_caddr_q <= '0;
            valid_out_q <= 1'b0; vec_out_q <= '0;
            eof_out_q <= '0; bof_out_q <= '0; chain_out_q <= '0;
            for (int a = 0; a < VVRF_SIZE; a++) vvrf_q[a] <= '0;
        end else begin
            s1_valid_q  <= valid_in && tracing;
            s1_vec_q    <= vector_in;
            s1_opnd_q   <= opnd_d;
            s1_eof_q    <= eof_in;
            s1_bof_q    <= bof_in;
            s1_chain_q  <= chainId_in;
            s1_op_q     <= act_op_q[chainId_in];
            s1_cond_q   <= act_cond_q[chainId_in];
            s1_cache_q  <= act_cache_q[chainId_in];
            s1_caddr_q  <= act_caddr_q[chainId_in];
            valid_out_q <= s1_valid_q && tracing;
            vec_out_q   <= res_d;
            eof_out_q   <= s1_eof_q;
            bof_out_q   <= s1_bof_q;
            chain_out_q <= s1_chain_q;
            if (wr_en) vvrf_q[s1_caddr_q] <= res_d;
        end
    end

    assign vector_out  = vec_out_q;
    assign valid_out   = valid_out_q;
    assign eof_out     = eof_out_q;
    assign bof_out     = bof_out_q;
    assign chainId_out = chain_out_q;
    assign cfg_done    = done_q;
    assign cfg_error   = err_q;
endmodule
